// File: rtl/lwb_pkg.sv
// rtl/lwb_pkg.sv - shared types and width helpers for the line window buffer
package lwb_pkg;

    localparam int PIX_W_DEF = 30;

    typedef logic [PIX_W_DEF-1:0] pixel_t;

    typedef enum logic {
        BORDER_ZERO = 1'b0,
        BORDER_REPL = 1'b1
    } border_mode_e;

    // Bits needed to hold values 0..n-1, never less than one bit.
    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/line_window_buffer_if.sv
// rtl/line_window_buffer_if.sv - pixel-in / column-out handshake bundle
interface line_window_buffer_if #(
    parameter int PIX_W  = 30,
    parameter int N_ROWS = 3,
    parameter int CNT_W  = 13
) ();
    logic                    i_sof;
    logic                    i_valid;
    logic [PIX_W-1:0]        i_pixel;
    logic                    o_ready;
    logic                    o_valid;
    logic [N_ROWS*PIX_W-1:0] o_column;
    logic [CNT_W-1:0]        o_x;
    logic [CNT_W-1:0]        o_y;
    logic                    o_full;
    logic                    i_ready;
    logic                    o_pause;
    logic                    o_sof_err;

    // Pixel source and column sink side
    modport master (
        output i_sof, i_valid, i_pixel, i_ready,
        input  o_ready, o_valid, o_column, o_x, o_y, o_full, o_pause, o_sof_err
    );

    // Line buffer side
    modport slave (
        input  i_sof, i_valid, i_pixel, i_ready,
        output o_ready, o_valid, o_column, o_x, o_y, o_full, o_pause, o_sof_err
    );
endinterface

// File: rtl/lwb_line_mem.sv
// rtl/lwb_line_mem.sv - one image line of pixel storage with read-before-write
module lwb_line_mem #(
    parameter int W     = 30,
    parameter int DEPTH = 640,
    parameter int AW    = 10
) (
    input  logic          i_clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_addr,
    input  logic [W-1:0]  i_wdata,
    output logic [W-1:0]  o_rdata
);
    // Contents are never cleared; the owner masks stale rows.
    logic [W-1:0] mem_q [DEPTH];

    // Store the incoming word; the read below still sees the old value this cycle
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            mem_q[i_addr] <= i_wdata;
        end
    end

    assign o_rdata = mem_q[i_addr];
endmodule

// File: rtl/line_window_buffer.sv
// rtl/line_window_buffer.sv - raster pixel stream to vertical N_ROWS column stream
module line_window_buffer
    import lwb_pkg::*;
#(
    parameter int PIX_W       = 30,
    parameter int IMG_W       = 640,
    parameter int N_ROWS      = 3,
    parameter int BORDER_MODE = 0,
    parameter int CNT_W       = 13
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    line_window_buffer_if.slave  bus
);
    localparam int NL   = N_ROWS - 1;
    localparam int AW   = clog2_min1(IMG_W);
    localparam int RS_W = clog2_min1(N_ROWS);
    localparam bit REPL = (BORDER_MODE == int'(BORDER_REPL));
    localparam logic [CNT_W-1:0] X_LAST = CNT_W'(IMG_W - 1);
    localparam logic [RS_W-1:0]  RS_MAX = RS_W'(N_ROWS - 1);

    logic [CNT_W-1:0]        x_q, x_d, y_q, y_d;
    logic [RS_W-1:0]         rs_q, rs_d;
    logic [CNT_W-1:0]        x_eff, y_eff;
    logic [RS_W-1:0]         rs_eff;
    logic                    valid_q, valid_d;
    logic                    full_q, full_d;
    logic                    err_q, err_d;
    logic [CNT_W-1:0]        ox_q, ox_d, oy_q, oy_d;
    logic [N_ROWS*PIX_W-1:0] col_q, col_d, col_sel;
    logic [PIX_W-1:0]        repl_pix;
    logic                    ready;
    logic                    accept;
    logic [PIX_W-1:0]        rd [NL];

    assign ready  = ~valid_q | bus.i_ready;
    assign accept = bus.i_valid & ready;

    // A start-of-frame pixel is placed at the origin with no history behind it.
    assign x_eff  = bus.i_sof ? '0 : x_q;
    assign y_eff  = bus.i_sof ? '0 : y_q;
    assign rs_eff = bus.i_sof ? '0 : rs_q;

    // Line k holds the row k+1 above the current one; each accept shifts the column down one line.
    for (genvar k = 0; k < NL; k++) begin : g_line
        logic [PIX_W-1:0] wdata;
        if (k == 0) begin : g_first
            assign wdata = bus.i_pixel;
        end else begin : g_next
            assign wdata = rd[k-1];
        end
        lwb_line_mem #(.W(PIX_W), .DEPTH(IMG_W), .AW(AW)) u_mem (
            .i_clk   (i_clk),
            .i_we    (accept),
            .i_addr  (x_eff[AW-1:0]),
            .i_wdata (wdata),
            .o_rdata (rd[k])
        );
    end

    // Assemble the column, masking rows older than the frame has produced
    always_comb begin
        repl_pix = bus.i_pixel;
        for (int k = 1; k < N_ROWS; k++) begin
            if (RS_W'(k) == rs_eff) begin
                repl_pix = rd[k-1];
            end
        end
        col_sel = '0;
        col_sel[PIX_W-1:0] = bus.i_pixel;
        for (int k = 1; k < N_ROWS; k++) begin
            if (RS_W'(k) <= rs_eff) begin
                col_sel[k*PIX_W +: PIX_W] = rd[k-1];
            end else if (REPL) begin
                col_sel[k*PIX_W +: PIX_W] = repl_pix;
            end else begin
                col_sel[k*PIX_W +: PIX_W] = '0;
            end
        end
    end

    // Advance raster position and row history on each accepted pixel
    always_comb begin
        x_d  = x_q;
        y_d  = y_q;
        rs_d = rs_q;
        if (accept) begin
            if (x_eff == X_LAST) begin
                x_d  = '0;
                y_d  = (y_eff == '1) ? y_eff : y_eff + 1'b1;
                rs_d = (rs_eff == RS_MAX) ? rs_eff : rs_eff + 1'b1;
            end else begin
                x_d  = x_eff + 1'b1;
                y_d  = y_eff;
                rs_d = rs_eff;
            end
        end
    end

    // Output register: load on accept, hold while the sink stalls
    always_comb begin
        valid_d = accept | (valid_q & ~bus.i_ready);
        col_d   = col_q;
        ox_d    = ox_q;
        oy_d    = oy_q;
        full_d  = full_q;
        err_d   = err_q | (accept & bus.i_sof & (x_q != '0));
        if (accept) begin
            col_d  = col_sel;
            ox_d   = x_eff;
            oy_d   = y_eff;
            full_d = (rs_eff == RS_MAX);
        end
    end

    // State registers
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            x_q     <= '0;
            y_q     <= '0;
            rs_q    <= '0;
            valid_q <= 1'b0;
            col_q   <= '0;
            ox_q    <= '0;
            oy_q    <= '0;
            full_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            x_q     <= x_d;
            y_q     <= y_d;
            rs_q    <= rs_d;
            valid_q <= valid_d;
            col_q   <= col_d;
            ox_q    <= ox_d;
            oy_q    <= oy_d;
            full_q  <= full_d;
            err_q   <= err_d;
        end
    end

    assign bus.o_ready   = ready;
    assign bus.o_pause   = ~ready;
    assign bus.o_valid   = valid_q;
    assign bus.o_column  = col_q;
    assign bus.o_x       = ox_q;
    assign bus.o_y       = oy_q;
    assign bus.o_full    = full_q;
    assign bus.o_sof_err = err_q;
endmodule

// File: tb/tb_line_window_buffer.sv
// tb/tb_line_window_buffer.sv - self-checking bench for line_window_buffer in both border modes
module tb_line_window_buffer;
    localparam int PW = 8;
    localparam int IW = 4;
    localparam int NR = 3;
    localparam int CW = 13;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic sof = 1'b0;
    logic valid = 1'b0;
    logic ready = 1'b1;
    logic [PW-1:0] pix = '0;
    bit rand_mode = 1'b0;

    int tests = 0;
    int fails = 0;

    line_window_buffer_if #(.PIX_W(PW), .N_ROWS(NR), .CNT_W(CW)) bus0 ();
    line_window_buffer_if #(.PIX_W(PW), .N_ROWS(NR), .CNT_W(CW)) bus1 ();

    assign bus0.i_sof = sof;
    assign bus0.i_valid = valid;
    assign bus0.i_pixel = pix;
    assign bus0.i_ready = ready;
    assign bus1.i_sof = sof;
    assign bus1.i_valid = valid;
    assign bus1.i_pixel = pix;
    assign bus1.i_ready = ready;

    line_window_buffer #(.PIX_W(PW), .IMG_W(IW), .N_ROWS(NR), .BORDER_MODE(0), .CNT_W(CW)) dut0 (
        .i_clk(clk), .i_rst(rst), .bus(bus0.slave));
    line_window_buffer #(.PIX_W(PW), .IMG_W(IW), .N_ROWS(NR), .BORDER_MODE(1), .CNT_W(CW)) dut1 (
        .i_clk(clk), .i_rst(rst), .bus(bus1.slave));

    initial forever #5 clk = ~clk;

    // Reference model: frame rows kept in a ring, indexed by rows since start of frame
    logic [PW-1:0] fr [2][4][IW];
    int mx [2];
    int mrow [2];
    bit pend [2];
    bit eerr [2];
    logic [NR*PW-1:0] ecol [2];
    int ex [2];
    int ey [2];
    bit efull [2];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            mx[m] = 0;
            mrow[m] = 0;
            pend[m] = 1'b0;
            eerr[m] = 1'b0;
        end
    endtask

    task automatic model_accept(input int m, input bit s, input logic [PW-1:0] p);
        int x, row, rs;
        logic [PW-1:0] v;
        x = s ? 0 : mx[m];
        row = s ? 0 : mrow[m];
        rs = (row < NR - 1) ? row : NR - 1;
        if (s && mx[m] != 0) eerr[m] = 1'b1;
        fr[m][row % 4][x] = p;
        ecol[m] = '0;
        for (int k = 0; k < NR; k++) begin
            if (k <= rs) v = fr[m][(row - k) % 4][x];
            else if (m == 1) v = fr[m][(row - rs) % 4][x];
            else v = '0;
            ecol[m][k*PW +: PW] = v;
        end
        ex[m] = x;
        ey[m] = (row > 8191) ? 8191 : row;
        efull[m] = (rs == NR - 1);
        pend[m] = 1'b1;
        if (x == IW - 1) begin
            mx[m] = 0;
            mrow[m] = row + 1;
        end else begin
            mx[m] = x + 1;
            mrow[m] = row;
        end
    endtask

    task automatic side(input int m, input logic ov, input logic [NR*PW-1:0] col,
                        input logic [CW-1:0] ox, input logic [CW-1:0] oy, input logic of,
                        input logic oerr, input logic ordy, input logic opause);
        bit mready;
        mready = !pend[m] || ready;
        chk($sformatf("m%0d o_valid", m), ov, pend[m]);
        if (pend[m] && ov) begin
            chk($sformatf("m%0d o_column", m), col, ecol[m]);
            chk($sformatf("m%0d o_x", m), ox, ex[m]);
            chk($sformatf("m%0d o_y", m), oy, ey[m]);
            chk($sformatf("m%0d o_full", m), of, efull[m]);
        end
        chk($sformatf("m%0d o_sof_err", m), oerr, eerr[m]);
        chk($sformatf("m%0d o_ready", m), ordy, mready);
        chk($sformatf("m%0d o_pause", m), opause, !mready);
        if (pend[m] && ready) pend[m] = 1'b0;
        if (valid && mready) model_accept(m, sof, pix);
    endtask

    // Compare process: every cycle outside reset, mid-cycle
    initial forever begin
        @(negedge clk);
        if (!rst) begin
            side(0, bus0.o_valid, bus0.o_column, bus0.o_x, bus0.o_y, bus0.o_full,
                 bus0.o_sof_err, bus0.o_ready, bus0.o_pause);
            side(1, bus1.o_valid, bus1.o_column, bus1.o_x, bus1.o_y, bus1.o_full,
                 bus1.o_sof_err, bus1.o_ready, bus1.o_pause);
        end
    end

    task automatic send(input logic [PW-1:0] p, input bit s);
        bit acc;
        int cnt;
        pix = p;
        sof = s;
        valid = 1'b1;
        acc = 1'b0;
        cnt = 0;
        while (!acc && cnt < 200) begin
            @(negedge clk);
            acc = bus0.o_ready;
            @(posedge clk);
            #1;
            cnt++;
            if (rand_mode) ready = ($urandom_range(0, 3) != 0);
        end
        valid = 1'b0;
        sof = 1'b0;
        if (!acc) chk("send timeout", 0, 1);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            if (rand_mode) ready = ($urandom_range(0, 3) != 0);
        end
    endtask

    task automatic pin(input string name, input logic [NR*PW-1:0] c0, input logic [NR*PW-1:0] c1,
                       input int x, input int y, input bit full);
        chk({name, " m0 col"}, bus0.o_column, c0);
        chk({name, " m1 col"}, bus1.o_column, c1);
        chk({name, " x"}, bus0.o_x, x);
        chk({name, " y"}, bus0.o_y, y);
        chk({name, " full"}, bus0.o_full, full);
    endtask

    task automatic check_zero(input string name);
        chk({name, " m0 valid"}, bus0.o_valid, 0);
        chk({name, " m0 col"}, bus0.o_column, 0);
        chk({name, " m0 x"}, bus0.o_x, 0);
        chk({name, " m0 y"}, bus0.o_y, 0);
        chk({name, " m0 full"}, bus0.o_full, 0);
        chk({name, " m0 err"}, bus0.o_sof_err, 0);
        chk({name, " m1 valid"}, bus1.o_valid, 0);
        chk({name, " m1 col"}, bus1.o_column, 0);
    endtask

    initial begin
        model_reset();
        #1 rst = 1'b1;
        #1 check_zero("reset");
        @(posedge clk);
        #1 rst = 1'b0;

        // Stream 1..12 with sof on the first pixel
        for (int i = 1; i <= 12; i++) begin
            send(8'(i), i == 1);
            if (i == 3)  pin("p3", 24'h000003, 24'h030303, 2, 0, 0);
            if (i == 5)  pin("p5", 24'h000105, 24'h010105, 0, 1, 0);
            if (i == 10) pin("p10", 24'h02060A, 24'h02060A, 1, 2, 1);
        end

        // Backpressure: hold the first column, then release with the next pixel waiting
        idle(2);
        send(8'h21, 1'b1);
        ready = 1'b0;
        pix = 8'h22;
        valid = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
            chk("bp valid", bus0.o_valid, 1);
            chk("bp col", bus0.o_column, 24'h000021);
            chk("bp ready", bus0.o_ready, 0);
            chk("bp pause", bus0.o_pause, 1);
        end
        ready = 1'b1;
        @(posedge clk);
        #1;
        valid = 1'b0;
        chk("bp release valid", bus0.o_valid, 1);
        pin("bp release", 24'h000022, 24'h222222, 1, 0, 0);

        // Start of frame arriving at x=2
        send(8'h23, 1'b1);
        chk("sof err m0", bus0.o_sof_err, 1);
        chk("sof err m1", bus1.o_sof_err, 1);
        pin("sof mid", 24'h000023, 24'h232323, 0, 0, 0);
        send(8'h24, 1'b0);
        chk("sof err sticky", bus0.o_sof_err, 1);

        // Reset in the middle of row 1
        for (int i = 0; i < 6; i++) send(8'h31 + 8'(i), i == 0);
        rst = 1'b1;
        #1 check_zero("mid reset");
        model_reset();
        @(posedge clk);
        #1 rst = 1'b0;
        send(8'h55, 1'b0);
        pin("after reset", 24'h000055, 24'h555555, 0, 0, 0);
        for (int i = 1; i < 5; i++) send(8'h55 + 8'(i), 1'b0);
        pin("after reset row1", 24'h005559, 24'h555559, 0, 1, 0);

        // Random traffic over three frames
        rand_mode = 1'b1;
        for (int f = 0; f < 3; f++) begin
            for (int i = 0; i < IW * 5; i++) begin
                idle($urandom_range(0, 2));
                send(8'($urandom), i == 0);
            end
        end
        rand_mode = 1'b0;
        ready = 1'b1;
        idle(3);
        chk("drained", bus0.o_valid, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/line_window_buffer.md
Name: line_window_buffer

Overview:
- Parametrised streaming line buffer for the camera processing path. Sits between the SDRAM pixel read-out and the stroke/edge filters.
- Accepts one packed RGB pixel per handshake in raster order. Emits a vertical column of N_ROWS vertically aligned pixels (same x, consecutive rows) plus coordinates, so downstream kernels can form windows.
- Successor to the fixed 2-read-port staging: generalised in row count, pixel width, image width and border mode, with valid/ready backpressure and a CCD pause output.

Parameters:
PIX_W, 30, packed pixel width (R,G,B at 10 bits each)
IMG_W, 640, pixels per line
N_ROWS, 3, rows per output column (>=2)
BORDER_MODE, 0, 0 = missing rows output as zero; 1 = missing rows replicate the oldest valid row
CNT_W, 13, width of x/y counters (matches the H/V counter width)

Ports:
i_clk  in  1  clock
i_rst  in  1  asynchronous reset, active-high
i_sof  in  1  start of frame, qualified by i_valid
i_valid  in  1  input pixel valid
i_pixel  in  PIX_W  input pixel
o_ready  out  1  block can accept a pixel
o_valid  out  1  output column valid
o_column  out  N_ROWS*PIX_W  slice 0 = current row y, slice k = row y-k
o_x  out  CNT_W  x of output column
o_y  out  CNT_W  y of output column
o_full  out  1  all N_ROWS rows of the column are real (y >= N_ROWS-1)
i_ready  in  1  downstream accepts column
o_pause  out  1  = ~o_ready; drives the CCD pause
o_sof_err  out  1  sticky; set when i_sof is accepted while x != 0

Behaviour:
- Reset (asynchronous, active-high): x=0, y=0, rows_seen=0, o_valid=0, o_column=0, o_x=0, o_y=0, o_full=0, o_sof_err=0. Line memory contents are not cleared; rows_seen masks stale data.
- Handshake: accept = i_valid & o_ready. o_ready = ~o_valid | i_ready (single output register, no combinational path from i_valid to o_ready). Output fields hold stable while o_valid & ~i_ready.
- Latency: a pixel accepted in cycle t produces its column with o_valid=1 in cycle t+1.
- Line memories: N_ROWS-1 arrays, each IMG_W deep. On accept at address x:
  - read all arrays before write (read-before-write in the same cycle);
  - write i_pixel into line 0 and old line k into line k+1.
  - The column is {old line N_ROWS-2 .. old line 0, i_pixel}.
- Counters on accept:
  - x increments; at x == IMG_W-1 it wraps to 0, y increments and rows_seen increments (saturating at N_ROWS-1).
  - y saturates at 2^CNT_W-1.
- SOF: on accept with i_sof=1, the pixel is treated as x=0, y=0 and rows_seen is reset to 0 for it. If the pre-accept x != 0, o_sof_err is set (sticky until reset).
- Border: slice k (k>=1) is valid iff k <= rows_seen.
  - Mode 0: invalid slices output 0.
  - Mode 1: invalid slices output slice rows_seen (the oldest valid row); in row 0 this is the current pixel.
- o_full = (rows_seen == N_ROWS-1), registered with the column.
- Simultaneous accept and output drain in the same cycle: the new column replaces the old, and o_valid stays 1.
- Reset mid-line: the next accepted pixel is x=0, y=0 regardless of i_sof.

Decomposition:
- Package lwb_pkg: pixel_t typedef (PIX_W), border mode enum (BORDER_ZERO, BORDER_REPL), and a counter-width localparam helper.
- One sub-module, lwb_line_mem: single line array with address, write enable, write data, and read-before-write combinational read data. Instantiate N_ROWS-1 times in a generate loop.

Test Plan (bench params IMG_W=4, N_ROWS=3, PIX_W=8, i_ready=1 unless stated):
- Stream pixel values 1..12 with i_sof on pixel 1, mode 0 -> at x=1,y=2 (pixel 10) o_column = {2,6,10}, o_full=1; at y=0 columns are {0,0,p}; o_x/o_y match.
- Same stream, mode 1 -> row 0 outputs {p,p,p}; row 1 at x=0 outputs {1,1,5}.
- Hold i_ready=0 after the first column -> o_valid stays 1, column stable, o_ready=0, o_pause=1; release i_ready -> the next pixel is accepted in the same cycle, with no loss or duplicate.
- Assert i_sof at x=2 -> o_sof_err=1 sticky; that pixel reports o_x=0, o_y=0, o_full=0, border masking applied.
- Assert i_rst mid-row 1 -> outputs 0 immediately; the next pixel (no sof) reports x=0, y=0, and stale line data does not appear (mode 0 slices are zero).
- Random i_valid/i_ready over 3 frames vs. reference model -> every accepted pixel yields exactly one column, in order.
